and2_share_arbiter: RTL and testbench
=====================================

Name: and2_share_arbiter

Overview:
- Shares one 2-input AND evaluation unit (And2-style, bitwise over WIDTH) between N_REQ requesters.
- Round-robin arbiter selects one valid requester per cycle and computes I0 & I1 for it. The result is captured in a single-entry output register tagged with the requester index.
- Sits between the requester-side datapaths and a single downstream consumer of AND results. Valid/ready handshakes on both sides.

Parameters:
- N_REQ, 4, number of requesters (>=1).
- WIDTH, 1, operand/result width in bits.
- ID_W, max(1, clog2(N_REQ)), width of the requester index tag.

Ports:
- CLK  input  1  clock, rising-edge.
- ASYNCRESET  input  1  asynchronous, active-high reset.
- req_valid  input  N_REQ  per-requester operand valid.
- req_ready  output  N_REQ  per-requester grant/accept; at most one bit high.
- req_I0  input  N_REQ*WIDTH  operand 0, requester k at bits [k*WIDTH +: WIDTH].
- req_I1  input  N_REQ*WIDTH  operand 1, same packing.
- out_valid  output  1  result register holds a valid result.
- out_ready  input  1  consumer accepts the result.
- out_O  output  WIDTH  registered req_I0[g] & req_I1[g].
- out_id  output  ID_W  index g of the requester that produced out_O.

Behaviour:
- Reset (ASYNCRESET=1, takes effect immediately, independent of CLK):
  - out_valid=0, out_O=0, out_id=0.
  - Round-robin pointer rr_ptr=0.
  - req_ready=0 while reset is asserted.
- Register state: EMPTY (out_valid=0) and FULL (out_valid=1).
- can_accept = !out_valid | out_ready (combinational).
- Selection (combinational): g = first k in order rr_ptr, rr_ptr+1, …, N_REQ-1, 0, …, rr_ptr-1 with req_valid[k]=1.
- req_ready[g] = can_accept & |req_valid. All other req_ready bits are 0. req_ready never depends on a requester's own valid except through selection.
- Transfer on a rising edge when req_valid[g] & req_ready[g]:
  - out_O <= req_I0[g] & req_I1[g] (bitwise, WIDTH bits, no extension).
  - out_id <= g.
  - out_valid <= 1.
  - rr_ptr <= (g+1) mod N_REQ, wrapping from N_REQ-1 to 0.
- Result drained without a new transfer (out_valid & out_ready, no transfer): out_valid <= 0; out_O and out_id hold their last values.
- Simultaneous drain and transfer in the same cycle: the new result replaces the old one and out_valid stays 1. Sustained throughput is 1 result/cycle.
- Latency: 1 cycle from accepted request to out_valid.
- Backpressure: when out_valid & !out_ready:
  - All req_ready bits are 0.
  - out_O, out_id, out_valid are held stable.
  - rr_ptr is unchanged.
- Requesters hold valid and operands until their ready is seen. The arbiter does not latch unaccepted requests.
- rr_ptr advances only on a transfer, never on idle cycles.
- No requests pending: req_ready all 0, no state change apart from any drain.
- N_REQ=1: selection degenerates to requester 0; out_id is constant 0.
- Reset mid-operation: any pending result is discarded (out_valid=0) and rr_ptr returns to 0. The first grant after reset release goes to the lowest-index valid requester.
- No X on outputs after reset, regardless of operand values.

Test Plan:
- Reset: hold ASYNCRESET=1 mid-cycle with out_valid=1 -> out_valid, out_O, out_id drop to 0 immediately, before the next CLK edge; req_ready=0.
- Single request: N_REQ=4, WIDTH=4; req_valid=0b0100, I0[2]=0xC, I1[2]=0xA -> req_ready=0b0100 that cycle; next cycle out_valid=1, out_O=0x8, out_id=2.
- Round-robin fairness: all four requesters valid continuously, out_ready=1 -> out_id sequence 0,1,2,3,0,1 on consecutive cycles; exactly one req_ready bit high each cycle.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles with req_valid=0b1111 -> req_ready=0, out_O/out_id unchanged. Raise out_ready -> the next grant is rr_ptr's requester and out_valid stays 1 with no bubble.
- Wrap/skip: rr_ptr=3, req_valid=0b0011 -> grant requester 0, then 1, then 0.
- Drain to empty: one request accepted, then req_valid=0 and out_ready=1 -> out_valid=1 for exactly one cycle, then 0; out_O retains its value.

Source files
------------

// File: rtl/and2_share_arbiter.sv
// Round-robin shared bitwise AND unit: one requester is granted per cycle and its
// I0 & I1 result lands in a single-entry output register tagged with the requester index.
//
// state | meaning
// EMPTY | output register holds no result (out_valid=0)
// FULL  | output register holds a result awaiting the consumer (out_valid=1)
module and2_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 1,
  parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   CLK,
  input  logic                   ASYNCRESET,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_I0,
  input  logic [N_REQ*WIDTH-1:0] req_I1,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_O,
  output logic [ID_W-1:0]        out_id
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [ID_W-1:0]   grant_id;
  logic              any_valid;
  logic              can_accept;
  logic              transfer;
  logic [WIDTH-1:0]  out_o_nxt;
  logic [ID_W-1:0]   out_id_nxt;
  logic [WIDTH-1:0]  i0_arr [N_REQ];
  logic [WIDTH-1:0]  i1_arr [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign i0_arr[k] = req_I0[k*WIDTH +: WIDTH];
    assign i1_arr[k] = req_I1[k*WIDTH +: WIDTH];
  end

  // Scan from the farthest offset back to rr_ptr so the closest valid requester wins.
  always_comb begin
    grant_id  = '0;
    any_valid = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      int s;
      s = int'(rr_ptr) + i;
      if (s >= N_REQ) s = s - N_REQ;
      if (req_valid[ID_W'(s)]) begin
        grant_id  = ID_W'(s);
        any_valid = 1'b1;
      end
    end
  end

  assign out_valid  = (state == FULL);
  assign can_accept = !out_valid || out_ready;
  assign transfer   = any_valid && can_accept;
  assign req_ready  = (transfer && !ASYNCRESET) ? (N_REQ'(1) << grant_id) : '0;

  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    out_o_nxt  = out_O;
    out_id_nxt = out_id;
    if (transfer) begin
      state_nxt  = FULL;
      out_o_nxt  = i0_arr[grant_id] & i1_arr[grant_id];
      out_id_nxt = grant_id;
      rr_ptr_nxt = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
    end else if (state == FULL && out_ready) begin
      state_nxt = EMPTY;
    end
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      state  <= EMPTY;
      rr_ptr <= '0;
      out_O  <= '0;
      out_id <= '0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
      out_O  <= out_o_nxt;
      out_id <= out_id_nxt;
    end
  end

endmodule

// File: tb/tb_and2_share_arbiter.sv
// Bench for and2_share_arbiter (N_REQ=4, WIDTH=4): directed vector table, async reset
// sequence, then random traffic checked against a behavioural model.
module tb_and2_share_arbiter;
  localparam int N = 4;
  localparam int W = 4;
  localparam int IW = 2;

  logic            CLK = 1'b0;
  logic            ASYNCRESET;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*W-1:0]  req_I0;
  logic [N*W-1:0]  req_I1;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_O;
  logic [IW-1:0]   out_id;

  and2_share_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .CLK(CLK), .ASYNCRESET(ASYNCRESET),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_I0(req_I0), .req_I1(req_I1),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_O(out_O), .out_id(out_id)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [N-1:0]   valid;
    logic [N*W-1:0] i0;
    logic [N*W-1:0] i1;
    logic           ordy;
    logic [N-1:0]   exp_ready;
    logic           exp_v;
    logic [W-1:0]   exp_o;
    logic [IW-1:0]  exp_id;
  } vec_t;

  vec_t vecs [14];

  // behavioural model of the output register and round-robin pointer
  logic          mv;
  logic [W-1:0]  mo;
  int            mid;
  int            mptr;

  task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                      input logic ordy);
    int g;
    logic can;
    logic [N-1:0] er;
    req_valid = v; req_I0 = a; req_I1 = b; out_ready = ordy;
    #1;
    can = !mv || ordy;
    g = -1;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (mptr + i) % N;
      if (g < 0 && ((v >> k) & 1) != 0) g = k;
    end
    er = (can && g >= 0) ? N'(1 << g) : '0;
    check("rnd_req_ready", 32'(req_ready), 32'(er));
    check("rnd_out_valid", 32'(out_valid), 32'(mv));
    check("rnd_out_O", 32'(out_O), 32'(mo));
    check("rnd_out_id", 32'(out_id), 32'(mid));
    @(posedge CLK); #1;
    if (er != 0) begin
      mv = 1'b1;
      mo = W'((a >> (W * g)) & (b >> (W * g)));
      mid = g;
      mptr = (g + 1) % N;
    end else if (mv && ordy) begin
      mv = 1'b0;
    end
  endtask

  initial begin
    vecs[0]  = '{4'b0100, 16'h0C00, 16'h0A00, 1'b1, 4'b0100, 1'b1, 4'h8, 2'd2};
    vecs[1]  = '{4'b0011, 16'h00F3, 16'h0065, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0};
    vecs[2]  = '{4'b0011, 16'h00F3, 16'h0065, 1'b1, 4'b0010, 1'b1, 4'h6, 2'd1};
    vecs[3]  = '{4'b0011, 16'h00F3, 16'h0065, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0};
    vecs[4]  = '{4'b0000, 16'h0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 4'h1, 2'd0};
    vecs[5]  = '{4'b0000, 16'hFFFF, 16'hFFFF, 1'b0, 4'b0000, 1'b0, 4'h1, 2'd0};
    vecs[6]  = '{4'b1111, 16'hFFFF, 16'h8421, 1'b0, 4'b0010, 1'b1, 4'h2, 2'd1};
    vecs[7]  = '{4'b1111, 16'hFFFF, 16'h8421, 1'b0, 4'b0000, 1'b1, 4'h2, 2'd1};
    vecs[8]  = '{4'b1111, 16'hFFFF, 16'h8421, 1'b0, 4'b0000, 1'b1, 4'h2, 2'd1};
    vecs[9]  = '{4'b1111, 16'hFFFF, 16'h8421, 1'b0, 4'b0000, 1'b1, 4'h2, 2'd1};
    vecs[10] = '{4'b1111, 16'hFFFF, 16'h8421, 1'b1, 4'b0100, 1'b1, 4'h4, 2'd2};
    vecs[11] = '{4'b1111, 16'hFFFF, 16'h8421, 1'b1, 4'b1000, 1'b1, 4'h8, 2'd3};
    vecs[12] = '{4'b1111, 16'hFFFF, 16'h8421, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0};
    vecs[13] = '{4'b1111, 16'hFFFF, 16'h8421, 1'b1, 4'b0010, 1'b1, 4'h2, 2'd1};

    ASYNCRESET = 1'b1;
    req_valid = 4'hF; req_I0 = 16'hFFFF; req_I1 = 16'hFFFF; out_ready = 1'b0;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_O", 32'(out_O), 32'd0);
    check("rst_out_id", 32'(out_id), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    @(negedge CLK) ASYNCRESET = 1'b0;
    @(posedge CLK); #1;

    for (int i = 0; i < 14; i++) begin
      req_valid = vecs[i].valid; req_I0 = vecs[i].i0; req_I1 = vecs[i].i1;
      out_ready = vecs[i].ordy;
      #1;
      check($sformatf("vec%0d_req_ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
      @(posedge CLK); #1;
      check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_v));
      check($sformatf("vec%0d_out_O", i), 32'(out_O), 32'(vecs[i].exp_o));
      check($sformatf("vec%0d_out_id", i), 32'(out_id), 32'(vecs[i].exp_id));
    end

    // mid-cycle reset while a result is held under backpressure
    req_valid = 4'hF; out_ready = 1'b0;
    #2;
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    ASYNCRESET = 1'b1;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_out_O", 32'(out_O), 32'd0);
    check("async_rst_out_id", 32'(out_id), 32'd0);
    check("async_rst_req_ready", 32'(req_ready), 32'd0);
    @(posedge CLK);
    req_valid = '0;
    @(negedge CLK) ASYNCRESET = 1'b0;
    @(posedge CLK); #1;

    mv = 1'b0; mo = '0; mid = 0; mptr = 0;
    step(4'b1010, 16'h5A5A, 16'hF0F0, 1'b1);
    check("post_rst_first_id", 32'(out_id), 32'd1);

    for (int c = 0; c < 400; c++) begin
      step(N'($urandom_range(0, 15)), N*W'($urandom), N*W'($urandom), ($urandom % 4) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit 200000 expected less");
    $fatal(1, "timeout");
  end
endmodule
